guess_round_sequencer: RTL and testbench

//  Game-phase controller for the guessing game: sequences each round through target load,

---
 rtl/guess_round_sequencer.sv | 164 ++++++++++++++++
 tb/tb_guess_round_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_round_sequencer.sv
// Round controller for the guessing game: LOAD -> SHOW -> GUESS -> WIN/LOSE -> IDLE,
// timed by the 1 Hz tick stream. Every output comes straight from a register.
module guess_round_sequencer #(
    parameter int W          = 4,
    parameter int SHOW_SEC   = 2,
    parameter int GUESS_SEC  = 10,
    parameter int RESULT_SEC = 5,
    parameter int MAX_TRIES  = 3
) (
    input  logic         clk,
    input  logic         resetSW,
    input  logic         tick_1hz,
    input  logic         start_btn,
    input  logic         guess_valid,
    input  logic [W-1:0] guess,
    input  logic [W-1:0] target,
    output logic [2:0]   state,
    output logic         load_target,
    output logic         show_target,
    output logic [3:0]   seconds_left,
    output logic [2:0]   tries_left,
    output logic         hint_hi,
    output logic         hint_lo,
    output logic [7:0]   score
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHOW  = 3'd2,
        S_GUESS = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_target;
    logic [3:0]   r_sec;
    logic [2:0]   r_tries;
    logic         r_hint_hi;
    logic         r_hint_lo;
    logic [7:0]   r_score;
    logic         r_load;
    logic         r_show;

    state_t       w_state_next;
    logic [W-1:0] w_target_next;
    logic [3:0]   w_sec_next;
    logic [2:0]   w_tries_next;
    logic         w_hint_hi_next;
    logic         w_hint_lo_next;
    logic [7:0]   w_score_next;
    logic         w_hit;
    logic         w_expire;
    logic         w_out_of_tries;

    assign w_hit          = (guess == r_target);
    assign w_expire       = tick_1hz && (r_sec == 4'd1);
    assign w_out_of_tries = guess_valid && !w_hit && (r_tries == 3'd1);

    always_comb begin
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_sec_next     = r_sec;
        w_tries_next   = r_tries;
        w_hint_hi_next = r_hint_hi;
        w_hint_lo_next = r_hint_lo;
        w_score_next   = r_score;

        case (r_state)
            S_IDLE: begin
                if (start_btn) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_target_next = target;
                w_state_next  = S_SHOW;
                w_sec_next    = 4'(SHOW_SEC);
            end
            S_SHOW: begin
                if (w_expire) begin
                    w_state_next   = S_GUESS;
                    w_sec_next     = 4'(GUESS_SEC);
                    w_tries_next   = 3'(MAX_TRIES);
                    w_hint_hi_next = 1'b0;
                    w_hint_lo_next = 1'b0;
                end else if (tick_1hz) begin
                    w_sec_next = r_sec - 4'd1;
                end
            end
            S_GUESS: begin
                // A guess landing on the expiring tick is judged first; only a hit escapes LOSE.
                if (guess_valid && w_hit) begin
                    w_state_next = S_WIN;
                    w_sec_next   = 4'(RESULT_SEC);
                    if (r_score != 8'hFF) begin
                        w_score_next = r_score + 8'd1;
                    end
                end else begin
                    if (guess_valid) begin
                        w_hint_hi_next = (guess > r_target);
                        w_hint_lo_next = (guess < r_target);
                        if (!w_out_of_tries) begin
                            w_tries_next = r_tries - 3'd1;
                        end
                    end
                    if (w_out_of_tries || w_expire) begin
                        w_state_next = S_LOSE;
                        w_sec_next   = 4'(RESULT_SEC);
                    end else if (tick_1hz) begin
                        w_sec_next = r_sec - 4'd1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (w_expire) begin
                    w_state_next = S_IDLE;
                    w_sec_next   = 4'd0;
                end else if (tick_1hz) begin
                    w_sec_next = r_sec - 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_sec_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetSW) begin
            r_state   <= S_IDLE;
            r_target  <= '0;
            r_sec     <= 4'd0;
            r_tries   <= 3'd0;
            r_hint_hi <= 1'b0;
            r_hint_lo <= 1'b0;
            r_score   <= 8'd0;
            r_load    <= 1'b0;
            r_show    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_target  <= w_target_next;
            r_sec     <= w_sec_next;
            r_tries   <= w_tries_next;
            r_hint_hi <= w_hint_hi_next;
            r_hint_lo <= w_hint_lo_next;
            r_score   <= w_score_next;
            r_load    <= (w_state_next == S_LOAD);
            r_show    <= (w_state_next == S_SHOW);
        end
    end

    assign state        = r_state;
    assign load_target  = r_load;
    assign show_target  = r_show;
    assign seconds_left = r_sec;
    assign tries_left   = r_tries;
    assign hint_hi      = r_hint_hi;
    assign hint_lo      = r_hint_lo;
    assign score        = r_score;

endmodule

// File: tb/tb_guess_round_sequencer.sv
// Bench for guess_round_sequencer: directed round scenarios plus randomized traffic
// compared cycle-by-cycle against a round-level game model.
module tb_guess_round_sequencer;

    localparam int ST_IDLE  = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_SHOW  = 2;
    localparam int ST_GUESS = 3;
    localparam int ST_WIN   = 4;
    localparam int ST_LOSE  = 5;

    logic       clk = 1'b0;
    logic       resetSW;
    logic       tick_1hz;
    logic       start_btn;
    logic       guess_valid;
    logic [3:0] guess;
    logic [3:0] target;
    logic [2:0] state;
    logic       load_target;
    logic       show_target;
    logic [3:0] seconds_left;
    logic [2:0] tries_left;
    logic       hint_hi;
    logic       hint_lo;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;

    // Game model: phase, countdown, tries, hints, score, secret number.
    int m_phase = 0;
    int m_sec   = 0;
    int m_tries = 0;
    int m_hi    = 0;
    int m_lo    = 0;
    int m_score = 0;
    int m_tgt   = 0;

    guess_round_sequencer dut (
        .clk          (clk),
        .resetSW      (resetSW),
        .tick_1hz     (tick_1hz),
        .start_btn    (start_btn),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .target       (target),
        .state        (state),
        .load_target  (load_target),
        .show_target  (show_target),
        .seconds_left (seconds_left),
        .tries_left   (tries_left),
        .hint_hi      (hint_hi),
        .hint_lo      (hint_lo),
        .score        (score)
    );

    always #5 clk = ~clk;

    task automatic enter_result(input int won);
        m_phase = won ? ST_WIN : ST_LOSE;
        m_sec   = 5;
        if (won != 0 && m_score < 255) m_score = m_score + 1;
    endtask

    // One second of game time elapses in a timed phase.
    task automatic countdown(input int next_phase);
        if (m_sec > 1) begin
            m_sec = m_sec - 1;
        end else if (next_phase == ST_GUESS) begin
            m_phase = ST_GUESS; m_sec = 10; m_tries = 3; m_hi = 0; m_lo = 0;
        end else if (next_phase == ST_LOSE) begin
            enter_result(0);
        end else begin
            m_phase = ST_IDLE; m_sec = 0;
        end
    endtask

    task automatic model_step();
        int g;
        if (resetSW) begin
            m_phase = ST_IDLE; m_sec = 0; m_tries = 0; m_hi = 0; m_lo = 0; m_score = 0; m_tgt = 0;
            return;
        end
        g = int'(guess);
        if (m_phase == ST_IDLE) begin
            if (start_btn) m_phase = ST_LOAD;
        end else if (m_phase == ST_LOAD) begin
            m_tgt = int'(target); m_phase = ST_SHOW; m_sec = 2;
        end else if (m_phase == ST_SHOW) begin
            if (tick_1hz) countdown(ST_GUESS);
        end else if (m_phase == ST_GUESS) begin
            if (guess_valid && g == m_tgt) begin
                enter_result(1);
            end else if (guess_valid && m_tries == 1) begin
                m_hi = (g > m_tgt); m_lo = (g < m_tgt);
                enter_result(0);
            end else begin
                if (guess_valid) begin
                    m_hi = (g > m_tgt); m_lo = (g < m_tgt); m_tries = m_tries - 1;
                end
                if (tick_1hz) countdown(ST_LOSE);
            end
        end else begin
            if (tick_1hz) countdown(ST_IDLE);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        model_step();
        #1;
        start_btn   = 1'b0;
        tick_1hz    = 1'b0;
        guess_valid = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick_1hz = 1'b1;
            clk1();
            clk1();
        end
    endtask

    task automatic do_guess(input logic [3:0] g);
        guess = g; guess_valid = 1'b1;
        clk1();
    endtask

    task automatic start_round(input logic [3:0] t);
        start_btn = 1'b1;
        clk1();
        target = t;
        clk1();
        do_ticks(2);
    endtask

    task automatic apply_reset();
        resetSW = 1'b1;
        clk1();
        resetSW = 1'b0;
    endtask

    task automatic test_reset();
        resetSW = 1'b1; start_btn = 1'b1; tick_1hz = 1'b1; guess_valid = 1'b1;
        clk1();
        start_btn = 1'b1;
        clk1();
        resetSW = 1'b0;
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
        n_vec++; if (load_target !== 1'b0) begin n_err++; $display("FAIL reset_load got %b exp 0", load_target); end
        n_vec++; if (show_target !== 1'b0) begin n_err++; $display("FAIL reset_show got %b exp 0", show_target); end
        n_vec++; if (seconds_left !== 4'd0) begin n_err++; $display("FAIL reset_sec got %0d exp 0", seconds_left); end
        n_vec++; if (tries_left !== 3'd0) begin n_err++; $display("FAIL reset_tries got %0d exp 0", tries_left); end
        n_vec++; if ({hint_hi, hint_lo} !== 2'b00) begin n_err++; $display("FAIL reset_hints got %b exp 00", {hint_hi, hint_lo}); end
        n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL reset_score got %0d exp 0", score); end
        $display("test_reset done");
    endtask

    task automatic test_show_sequence();
        tick_1hz = 1'b1;
        clk1();
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_ignores_tick got %0d exp 0", state); end
        start_btn = 1'b1;
        clk1();
        n_vec++; if ({state, load_target} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL load_pulse got st=%0d ld=%b exp st=1 ld=1", state, load_target); end
        target = 4'd7;
        clk1();
        n_vec++; if ({state, load_target, show_target, seconds_left} !== {3'd2, 1'b0, 1'b1, 4'd2}) begin
            n_err++; $display("FAIL show_entry got st=%0d ld=%b sh=%b sec=%0d exp st=2 ld=0 sh=1 sec=2", state, load_target, show_target, seconds_left); end
        do_ticks(1);
        n_vec++; if ({state, seconds_left} !== {3'd2, 4'd1}) begin n_err++; $display("FAIL show_tick1 got st=%0d sec=%0d exp st=2 sec=1", state, seconds_left); end
        do_ticks(1);
        n_vec++; if ({state, show_target, seconds_left, tries_left} !== {3'd3, 1'b0, 4'd10, 3'd3}) begin
            n_err++; $display("FAIL guess_entry got st=%0d sh=%b sec=%0d tries=%0d exp st=3 sh=0 sec=10 tries=3", state, show_target, seconds_left, tries_left); end
        $display("test_show_sequence done");
    endtask

    task automatic test_hints_win();
        // continues in GUESS from test_show_sequence with target 7, score 0
        do_guess(4'd9);
        n_vec++; if ({state, hint_hi, hint_lo, tries_left} !== {3'd3, 1'b1, 1'b0, 3'd2}) begin
            n_err++; $display("FAIL guess9 got st=%0d hi=%b lo=%b tries=%0d exp st=3 hi=1 lo=0 tries=2", state, hint_hi, hint_lo, tries_left); end
        do_guess(4'd3);
        n_vec++; if ({state, hint_hi, hint_lo, tries_left} !== {3'd3, 1'b0, 1'b1, 3'd1}) begin
            n_err++; $display("FAIL guess3 got st=%0d hi=%b lo=%b tries=%0d exp st=3 hi=0 lo=1 tries=1", state, hint_hi, hint_lo, tries_left); end
        do_guess(4'd7);
        n_vec++; if ({state, score, seconds_left} !== {3'd4, 8'd1, 4'd5}) begin
            n_err++; $display("FAIL guess7_win got st=%0d score=%0d sec=%0d exp st=4 score=1 sec=5", state, score, seconds_left); end
        n_vec++; if ({hint_lo, tries_left} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL win_holds_display got lo=%b tries=%0d exp lo=1 tries=1", hint_lo, tries_left); end
        start_btn = 1'b1; guess = 4'd7; guess_valid = 1'b1;
        clk1();
        do_ticks(4);
        n_vec++; if ({state, seconds_left, score} !== {3'd4, 4'd1, 8'd1}) begin
            n_err++; $display("FAIL win_hold got st=%0d sec=%0d score=%0d exp st=4 sec=1 score=1", state, seconds_left, score); end
        do_ticks(1);
        n_vec++; if ({state, seconds_left} !== {3'd0, 4'd0}) begin n_err++; $display("FAIL win_to_idle got st=%0d sec=%0d exp st=0 sec=0", state, seconds_left); end
        $display("test_hints_win done");
    endtask

    task automatic test_three_wrong();
        start_round(4'd7);
        do_guess(4'd1);
        do_guess(4'd15);
        n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL two_wrong_state got %0d exp 3", state); end
        do_guess(4'd8);
        n_vec++; if ({state, score, seconds_left, hint_hi} !== {3'd5, 8'd1, 4'd5, 1'b1}) begin
            n_err++; $display("FAIL third_wrong got st=%0d score=%0d sec=%0d hi=%b exp st=5 score=1 sec=5 hi=1", state, score, seconds_left, hint_hi); end
        do_ticks(5);
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL lose_to_idle got %0d exp 0", state); end
        $display("test_three_wrong done");
    endtask

    task automatic test_timeout();
        start_round(4'd7);
        do_ticks(9);
        n_vec++; if ({state, seconds_left} !== {3'd3, 4'd1}) begin n_err++; $display("FAIL nine_ticks got st=%0d sec=%0d exp st=3 sec=1", state, seconds_left); end
        do_ticks(1);
        n_vec++; if ({state, seconds_left} !== {3'd5, 4'd5}) begin n_err++; $display("FAIL timeout_lose got st=%0d sec=%0d exp st=5 sec=5", state, seconds_left); end
        do_ticks(5);
        start_round(4'd7);
        do_ticks(9);
        guess = 4'd7; guess_valid = 1'b1; tick_1hz = 1'b1;
        clk1();
        n_vec++; if ({state, score} !== {3'd4, 8'd2}) begin n_err++; $display("FAIL hit_on_expiry got st=%0d score=%0d exp st=4 score=2", state, score); end
        do_ticks(5);
        start_round(4'd7);
        do_ticks(9);
        guess = 4'd2; guess_valid = 1'b1; tick_1hz = 1'b1;
        clk1();
        n_vec++; if ({state, score, hint_lo} !== {3'd5, 8'd2, 1'b1}) begin
            n_err++; $display("FAIL miss_on_expiry got st=%0d score=%0d lo=%b exp st=5 score=2 lo=1", state, score, hint_lo); end
        do_ticks(5);
        $display("test_timeout done");
    endtask

    task automatic test_start_and_reset_in_guess();
        start_round(4'd5);
        start_btn = 1'b1;
        clk1();
        n_vec++; if ({state, seconds_left, tries_left} !== {3'd3, 4'd10, 3'd3}) begin
            n_err++; $display("FAIL start_in_guess got st=%0d sec=%0d tries=%0d exp st=3 sec=10 tries=3", state, seconds_left, tries_left); end
        resetSW = 1'b1; guess = 4'd5; guess_valid = 1'b1;
        clk1();
        resetSW = 1'b0;
        n_vec++; if ({state, score, seconds_left} !== {3'd0, 8'd0, 4'd0}) begin
            n_err++; $display("FAIL reset_mid_guess got st=%0d score=%0d sec=%0d exp st=0 score=0 sec=0", state, score, seconds_left); end
        $display("test_start_and_reset_in_guess done");
    endtask

    task automatic test_score_saturate();
        logic [3:0] t;
        int bad = 0;
        apply_reset();
        for (int r = 1; r <= 258; r++) begin
            t = 4'($urandom_range(0, 15));
            start_round(t);
            do_guess(t);
            n_vec++;
            if (score !== 8'((r > 255) ? 255 : r)) begin
                n_err++; bad++;
                if (bad < 5) $display("FAIL score_round%0d got %0d exp %0d", r, score, (r > 255) ? 255 : r);
            end
            do_ticks(5);
        end
        $display("test_score_saturate done");
    endtask

    task automatic test_random();
        logic [19:0] got;
        logic [19:0] exp;
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            resetSW     = ($urandom_range(0, 299) == 0);
            start_btn   = ($urandom_range(0, 7) == 0);
            tick_1hz    = ($urandom_range(0, 3) == 0);
            guess_valid = ($urandom_range(0, 5) == 0);
            guess       = ($urandom_range(0, 2) == 0) ? 4'(m_tgt) : 4'($urandom_range(0, 15));
            target      = 4'($urandom_range(0, 15));
            clk1();
            got = {state, load_target, show_target, seconds_left, tries_left, hint_hi, hint_lo, score};
            exp = {3'(m_phase), (m_phase == ST_LOAD), (m_phase == ST_SHOW), 4'(m_sec), 3'(m_tries),
                   (m_hi != 0), (m_lo != 0), 8'(m_score)};
            n_vec++;
            if (got !== exp) begin
                n_err++; bad++;
                if (bad < 10) $display("FAIL random_cycle%0d got %h exp %h", i, got, exp);
            end
        end
        resetSW = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        resetSW = 1'b0; tick_1hz = 1'b0; start_btn = 1'b0; guess_valid = 1'b0;
        guess = 4'd0; target = 4'd0;
        test_reset();
        test_show_sequence();
        test_hints_win();
        test_three_wrong();
        test_timeout();
        test_start_and_reset_in_guess();
        test_score_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
